// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered 3-to-8 handshake decoder.
//   state_e     : controller states (idle, single word pending, self-test sweep)
//   NInDefault  : default code width
//   onehot()    : binary code to one-hot vector, sized for the widest supported code;
//                 callers truncate to their own output width
package decoder_pkg;

  localparam int unsigned NInDefault = 3;
  localparam int unsigned MaxCodeW   = 6;
  localparam int unsigned MaxOutW    = 2 ** MaxCodeW;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StSweep
  } state_e;

  function automatic logic [MaxOutW-1:0] onehot(input logic [MaxCodeW-1:0] code);
    logic [MaxOutW-1:0] vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/dec_sweep_ctr.sv
// Sweep bookkeeping for decoder_3_8_hs: sweep code counter, dwell counter and
// terminal-code detection.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero both counters (held while not sweeping)
//   adv        : current sweep code accepted; step code, restart dwell
//   code       : current sweep code, one bit wider than the decoder code
//   dwell_ok   : dwell counter has reached SWEEP_DWELL-1
//   last       : current code is the final one (2**N_IN-1)
module dec_sweep_ctr
  import decoder_pkg::*;
#(
  parameter int unsigned N_IN        = NInDefault,
  parameter int unsigned SWEEP_DWELL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [N_IN:0] code,
  output logic          dwell_ok,
  output logic          last
);

  localparam int unsigned DwellW = (SWEEP_DWELL > 1) ? $clog2(SWEEP_DWELL) : 1;
  localparam int unsigned CodeW  = N_IN + 1;

  logic [N_IN:0]     code_q, code_d;
  logic [DwellW-1:0] dwell_q, dwell_d;

  assign dwell_ok = (dwell_q == DwellW'(SWEEP_DWELL - 1));
  // Extra counter bit means the terminal code is found by compare, not by wrap.
  assign last     = (code_q == CodeW'(2 ** N_IN - 1));
  assign code     = code_q;

  always_comb begin
    code_d  = code_q;
    dwell_d = dwell_q;
    if (clr) begin
      code_d  = '0;
      dwell_d = '0;
    end else if (adv) begin
      code_d  = code_q + CodeW'(1);
      dwell_d = '0;
    end else if (!dwell_ok) begin
      dwell_d = dwell_q + DwellW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q  <= '0;
      dwell_q <= '0;
    end else begin
      code_q  <= code_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/decoder_3_8_hs.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides and a
// self-test sweep that walks every code 0..2**N_IN-1 in order.
//   clk, rst_n          : clock, synchronous active-low reset
//   en                  : block enable; low forces idle with zero output next cycle
//   in_valid, in_code   : code to decode, taken when in_ready is also high
//   in_ready            : block can accept in_code this cycle
//   sweep               : level request to run a sweep (sampled when idle or freeing)
//   out, out_valid      : registered one-hot word and its valid
//   out_ready           : consumer accepts out this cycle
//   busy                : sweep in progress
//   sweep_done          : one-cycle pulse after the final sweep code is accepted
module decoder_3_8_hs
  import decoder_pkg::*;
#(
  parameter int unsigned N_IN        = NInDefault,
  parameter int unsigned SWEEP_DWELL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [N_IN-1:0]      in_code,
  output logic                 in_ready,
  input  logic                 sweep,
  output logic [2**N_IN-1:0]   out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 sweep_done
);

  localparam int unsigned OutW  = 2 ** N_IN;
  localparam int unsigned CodeW = N_IN + 1;

  state_e          state_q, state_d;
  logic [OutW-1:0] out_q, out_d;
  logic            sweep_done_q, sweep_done_d;

  logic            ctr_clr, ctr_adv, dwell_ok, last;
  logic [N_IN:0]   code, code_nxt;
  logic [OutW-1:0] in_onehot, sweep_onehot_nxt;
  logic            accept;

  dec_sweep_ctr #(
    .N_IN        (N_IN),
    .SWEEP_DWELL (SWEEP_DWELL)
  ) u_sweep_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ctr_clr),
    .adv      (ctr_adv),
    .code     (code),
    .dwell_ok (dwell_ok),
    .last     (last)
  );

  // Counters only run in SWEEP; everywhere else they sit at zero so entry is clean.
  assign ctr_clr = !en || (state_q != StSweep);
  assign ctr_adv = (state_q == StSweep) && dwell_ok && out_ready;

  assign code_nxt         = code + CodeW'(1);
  assign in_onehot        = OutW'(onehot(MaxCodeW'(in_code)));
  assign sweep_onehot_nxt = OutW'(onehot(MaxCodeW'(code_nxt)));

  assign accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      out_q        <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  // Next state.
  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    sweep_done_d = 1'b0;
    if (!en) begin
      // Abort: pending word or sweep dropped, no sweep_done.
      state_d = StIdle;
      out_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d = StHold;
            out_d   = in_onehot;
          end else if (sweep) begin
            state_d = StSweep;
            out_d   = OutW'(1);
          end
        end
        StHold: begin
          if (out_ready) begin
            if (accept) begin
              out_d = in_onehot;
            end else if (sweep) begin
              state_d = StSweep;
              out_d   = OutW'(1);
            end else begin
              state_d = StIdle;
              out_d   = '0;
            end
          end
        end
        StSweep: begin
          if (ctr_adv) begin
            if (last) begin
              state_d      = StIdle;
              out_d        = '0;
              sweep_done_d = 1'b1;
            end else begin
              out_d = sweep_onehot_nxt;
            end
          end
        end
        default: begin
          state_d = StIdle;
          out_d   = '0;
        end
      endcase
    end
  end

  // Outputs.
  always_comb begin
    in_ready   = en && rst_n && ((state_q == StIdle) || ((state_q == StHold) && out_ready));
    out_valid  = (state_q == StHold) || ((state_q == StSweep) && dwell_ok);
    busy       = (state_q == StSweep);
    out        = out_q;
    sweep_done = sweep_done_q;
  end

endmodule

// File: tb/tb_decoder_3_8_hs.sv
module tb_decoder_3_8_hs;

  logic       clk = 1'b0;
  logic       rst_n, en_a, en_b, in_valid, sweep, out_ready;
  logic [2:0] in_code;

  logic       in_ready_a, out_valid_a, busy_a, sweep_done_a;
  logic [7:0] out_a;
  logic       in_ready_b, out_valid_b, busy_b, sweep_done_b;
  logic [7:0] out_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_a = 0;
  int done_b = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int         xcyc_a[$];
  int         xcyc_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decoder_3_8_hs #(
    .N_IN        (3),
    .SWEEP_DWELL (1)
  ) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en_a),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_ready   (in_ready_a),
    .sweep      (sweep),
    .out        (out_a),
    .out_valid  (out_valid_a),
    .out_ready  (out_ready),
    .busy       (busy_a),
    .sweep_done (sweep_done_a)
  );

  decoder_3_8_hs #(
    .N_IN        (3),
    .SWEEP_DWELL (3)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en_b),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_ready   (in_ready_b),
    .sweep      (sweep),
    .out        (out_b),
    .out_valid  (out_valid_b),
    .out_ready  (out_ready),
    .busy       (busy_b),
    .sweep_done (sweep_done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake pops the next expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid_a === 1'b1 && out_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_a: unexpected word 0x%0h with empty queue", out_a);
      end else begin
        check("xfer_a", 32'(out_a), 32'(q_a.pop_front()));
      end
      xcyc_a.push_back(cyc);
    end
    if (rst_n === 1'b1 && out_valid_b === 1'b1 && out_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_b: unexpected word 0x%0h with empty queue", out_b);
      end else begin
        check("xfer_b", 32'(out_b), 32'(q_b.pop_front()));
      end
      xcyc_b.push_back(cyc);
    end
    if (sweep_done_a === 1'b1) done_a++;
    if (sweep_done_b === 1'b1) done_b++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, cnt, d0, bad;

    // 1. Reset
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; in_valid = 1'b0; sweep = 1'b0;
    out_ready = 1'b0; in_code = 3'd0;
    tick();
    tick();
    check("rst_out", 32'(out_a), 32'h00);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_sweep_done", 32'(sweep_done_a), 32'd0);
    en_a = 1'b1;
    #1;
    check("rst_in_ready_gated", 32'(in_ready_a), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready_released", 32'(in_ready_a), 32'd1);

    // 2. Back-to-back stream 0..7
    out_ready = 1'b1;
    xcyc_a.delete();
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_code  = 3'(i);
      q_a.push_back(8'(1) << i);
      check("t2_in_ready", 32'(in_ready_a), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("t2_xfer_count", 32'(xcyc_a.size()), 32'd8);
    check("t2_latency", 32'(xcyc_a[0]), 32'(c0 + 1));
    check("t2_no_bubble", 32'(xcyc_a[7] - xcyc_a[0]), 32'd7);
    check("t2_idle_after", 32'(out_valid_a), 32'd0);

    // 3. Held word under back-pressure
    in_valid  = 1'b1;
    in_code   = 3'd5;
    out_ready = 1'b0;
    q_a.push_back(8'h20);
    tick();
    in_code = 3'd2;
    for (int k = 0; k < 4; k++) begin
      check("t3_hold_out", 32'(out_a), 32'h20);
      check("t3_hold_valid", 32'(out_valid_a), 32'd1);
      check("t3_hold_in_ready", 32'(in_ready_a), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t3_release_out", 32'(out_a), 32'h00);
    check("t3_release_valid", 32'(out_valid_a), 32'd0);

    // 4. Sweep, dwell 1
    d0 = done_a;
    xcyc_a.delete();
    for (int k = 0; k < 8; k++) q_a.push_back(8'(1) << k);
    sweep = 1'b1;
    tick();
    sweep = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("t4_out", 32'(out_a), 32'(8'(1) << k));
      check("t4_busy", 32'(busy_a), 32'd1);
      check("t4_valid", 32'(out_valid_a), 32'd1);
      check("t4_in_ready", 32'(in_ready_a), 32'd0);
      tick();
    end
    check("t4_done_pulse", 32'(sweep_done_a), 32'd1);
    check("t4_end_busy", 32'(busy_a), 32'd0);
    check("t4_end_out", 32'(out_a), 32'h00);
    tick();
    check("t4_done_single", 32'(sweep_done_a), 32'd0);
    check("t4_done_count", 32'(done_a - d0), 32'd1);
    check("t4_xfer_count", 32'(xcyc_a.size()), 32'd8);

    // 5. Sweep, dwell 3 (second instance)
    en_a = 1'b0;
    en_b = 1'b1;
    tick();
    d0 = done_b;
    xcyc_b.delete();
    for (int k = 0; k < 8; k++) q_b.push_back(8'(1) << k);
    sweep = 1'b1;
    tick();
    sweep = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (sweep_done_b !== 1'b1 && cnt < 40);
    check("t5_sweep_len", 32'(cnt), 32'd24);
    check("t5_xfer_count", 32'(xcyc_b.size()), 32'd8);
    bad = 0;
    for (int k = 1; k < xcyc_b.size(); k++) if (xcyc_b[k] - xcyc_b[k-1] != 3) bad++;
    check("t5_dwell_spacing_bad", 32'(bad), 32'd0);
    tick();
    check("t5_done_count", 32'(done_b - d0), 32'd1);
    en_b = 1'b0;
    en_a = 1'b1;
    tick();

    // 6. Abort mid-sweep, restart with sweep still high
    d0 = done_a;
    for (int k = 0; k < 4; k++) q_a.push_back(8'(1) << k);
    sweep = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) tick();
    check("t6_at_10", 32'(out_a), 32'h10);
    en_a      = 1'b0;
    out_ready = 1'b0;
    tick();
    check("t6_abort_out", 32'(out_a), 32'h00);
    check("t6_abort_busy", 32'(busy_a), 32'd0);
    check("t6_abort_valid", 32'(out_valid_a), 32'd0);
    check("t6_abort_no_done", 32'(sweep_done_a), 32'd0);
    en_a      = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) q_a.push_back(8'(1) << k);
    tick();
    check("t6_restart_out", 32'(out_a), 32'h01);
    check("t6_restart_busy", 32'(busy_a), 32'd1);
    sweep = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (sweep_done_a !== 1'b1 && cnt < 20);
    check("t6_restart_len", 32'(cnt), 32'd8);
    tick();
    check("t6_done_count", 32'(done_a - d0), 32'd1);

    tick();
    tick();
    check("end_queue_a_empty", 32'(q_a.size()), 32'd0);
    check("end_queue_b_empty", 32'(q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
